// File: rtl/fp16_pkg.sv
// fp16_pkg: shared IEEE 754 binary16 definitions.
// Provides field widths, exponent constants, special encodings and a packed
// {sign, exp, frac} view of a half-precision word.
package fp16_pkg;

  localparam int unsigned EXP_W    = 5;
  localparam int unsigned FRAC_W   = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

endpackage

// File: rtl/fp_adder_lzc.sv
// fp_adder_lzc: 14-bit leading-zero counter for post-subtraction normalization.
//   value  in   14  word to scan, bit 13 is the most significant
//   count  out   4  number of leading zeros, 14 when value is all zero
module fp_adder_lzc (
  input  logic [13:0] value,
  output logic [3:0]  count
);

  // Ascending scan: the highest set bit is visited last and wins.
  always_comb begin
    count = 4'd14;
    for (int unsigned i = 0; i < 14; i++) begin
      if (value[i]) count = 4'(13 - i);
    end
  end

endmodule

// File: rtl/fp_adder.sv
// fp_adder: binary16 adder/subtractor, round-to-nearest-even, registered result.
//   clk    in    1  rising-edge clock
//   rst_n  in    1  asynchronous active-low reset, clears s to 0
//   a      in   16  operand A (binary16)
//   b      in   16  operand B (binary16)
//   sub    in    1  1 computes a - b, 0 computes a + b
//   s      out  16  result, one cycle after the operands
module fp_adder
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] s
);

  fp16_t       op_a, op_b, lg, sm;
  logic [4:0]  e_lg, e_sm, diff;
  logic [3:0]  shamt;
  logic [10:0] sig_lg, sig_sm;
  logic [26:0] wide;
  logic        sticky_sm, eff_sub;
  logic [13:0] lg_ext, sm_ext;
  logic [14:0] sum;
  logic [3:0]  lz;

  logic [15:0] s_d, s_q;

  // Unpack, order by magnitude, align and add.
  always_comb begin
    op_a = a;
    op_b = {b[15] ^ sub, b[14:0]};
    // For finite values the 15-bit magnitude field orders like the value.
    if (op_b[14:0] > op_a[14:0]) begin
      lg = op_b;
      sm = op_a;
    end else begin
      lg = op_a;
      sm = op_b;
    end
    e_lg   = (lg.exp == '0) ? 5'd1 : lg.exp;
    e_sm   = (sm.exp == '0) ? 5'd1 : sm.exp;
    sig_lg = {lg.exp != '0, lg.frac};
    sig_sm = {sm.exp != '0, sm.frac};
    diff   = e_lg - e_sm;
    // Any shift of 14 or more leaves only sticky; 15 keeps the wide window lossless.
    shamt  = (diff > 5'd15) ? 4'd15 : diff[3:0];
    wide   = {sig_sm, 16'b0} >> shamt;
    sticky_sm = |wide[13:0];
    sm_ext    = {wide[26:14], sticky_sm};
    lg_ext    = {sig_lg, 3'b000};
    eff_sub   = lg.sign ^ sm.sign;
    sum = eff_sub ? ({1'b0, lg_ext} - {1'b0, sm_ext})
                  : ({1'b0, lg_ext} + {1'b0, sm_ext});
  end

  fp_adder_lzc u_lzc (
    .value (sum[13:0]),
    .count (lz)
  );

  logic [4:0]  limit, sh;
  logic [13:0] norm;
  logic [5:0]  exp6, exp_field;
  logic [10:0] mant;
  logic        rnd_g, rnd_r, rnd_s, round_up;
  logic [15:0] packed_r;
  logic        a_nan, b_nan, a_inf, b_inf;

  // Normalize, round, pack and resolve special operands.
  always_comb begin
    limit = e_lg - 5'd1;
    sh    = '0;
    if (sum[14]) begin
      norm = {sum[14:2], sum[1] | sum[0]};
      exp6 = {1'b0, e_lg} + 6'd1;
    end else begin
      sh   = ({1'b0, lz} > limit) ? limit : {1'b0, lz};
      norm = sum[13:0] << sh;
      exp6 = {1'b0, e_lg} - {1'b0, sh};
    end
    exp_field = norm[13] ? exp6 : '0;
    mant      = norm[13:3];
    rnd_g     = norm[2];
    rnd_r     = norm[1];
    // A one-bit left shift can push the sticky position out; the small
    // operand's shifted-off bits still count toward rounding.
    rnd_s     = norm[0] | sticky_sm;
    round_up  = rnd_g & (rnd_r | rnd_s | mant[0]);
    // Mantissa carry ripples into the exponent, covering subnormal-to-normal.
    packed_r  = {exp_field, mant[9:0]} + {15'b0, round_up};

    a_nan = (op_a.exp == 5'(EXP_MAX)) && (op_a.frac != '0);
    b_nan = (op_b.exp == 5'(EXP_MAX)) && (op_b.frac != '0);
    a_inf = (op_a.exp == 5'(EXP_MAX)) && (op_a.frac == '0);
    b_inf = (op_b.exp == 5'(EXP_MAX)) && (op_b.frac == '0);

    if (a_nan || b_nan) begin
      s_d = QNAN;
    end else if (a_inf && b_inf) begin
      s_d = (op_a.sign != op_b.sign) ? QNAN : op_a;
    end else if (a_inf) begin
      s_d = op_a;
    end else if (b_inf) begin
      s_d = op_b;
    end else if (sum == '0) begin
      s_d = eff_sub ? 16'h0000 : {lg.sign, 15'b0};
    end else if (packed_r[15:10] >= 6'(EXP_MAX)) begin
      s_d = lg.sign ? NEG_INF : POS_INF;
    end else begin
      s_d = {lg.sign, packed_r[14:0]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_q <= '0;
    else        s_q <= s_d;
  end

  assign s = s_q;

endmodule

// File: tb/tb_fp_adder.sv
// tb_fp_adder: directed and randomized checks of fp_adder against an
// integer-domain binary16 reference (values held in units of 2^-24).
module tb_fp_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        sub;
  logic [15:0] s;

  int checks = 0;
  int errors = 0;

  fp_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sub   (sub),
    .s     (s)
  );

  always #5 clk = ~clk;

  function automatic longint mag(input logic [15:0] x);
    if (x[14:10] == 5'd0) return longint'(x[9:0]);
    return longint'(1024 + x[9:0]) << (x[14:10] - 1);
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y,
                                          input logic op_sub);
    logic [15:0] yy;
    longint va, vb, tot, n, q, rem, half;
    int p, shift, e;
    logic sgn;
    yy = {y[15] ^ op_sub, y[14:0]};
    if ((x[14:10] == 5'd31 && x[9:0] != 0) || (yy[14:10] == 5'd31 && yy[9:0] != 0))
      return 16'h7E00;
    if (x[14:10] == 5'd31 && yy[14:10] == 5'd31)
      return (x[15] != yy[15]) ? 16'h7E00 : x;
    if (x[14:10] == 5'd31) return x;
    if (yy[14:10] == 5'd31) return yy;
    va  = x[15]  ? -mag(x)  : mag(x);
    vb  = yy[15] ? -mag(yy) : mag(yy);
    tot = va + vb;
    if (tot == 0) return (x[15] && yy[15]) ? 16'h8000 : 16'h0000;
    sgn = (tot < 0);
    n   = sgn ? -tot : tot;
    p = 0;
    for (int i = 0; i < 48; i++) if (n[i]) p = i;
    if (p <= 10) return {sgn, n[14:0]};
    shift = p - 10;
    q    = n >> shift;
    rem  = n - (q << shift);
    half = longint'(1) << (shift - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == 2048) begin
      q = 1024;
      shift = shift + 1;
    end
    e = shift + 1;
    if (e >= 31) return sgn ? 16'hFC00 : 16'h7C00;
    return {sgn, 5'(e), q[9:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Applies one operation and checks s one clock later.
  task automatic do_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic op_sub, input logic [15:0] exp);
    a = x;
    b = y;
    sub = op_sub;
    @(posedge clk);
    #1;
    check(tag, s, exp);
  endtask

  logic [15:0] ra, rb;
  logic        rs;
  int          sel;

  initial begin
    rst_n = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    #1;
    check("reset_state", s, 16'h0000);
    a = 16'h3C00;
    b = 16'h3C00;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", s, 16'h0000);
    rst_n = 1'b1;

    do_op("tie_even_down", 16'h0FCC, 16'h8ADB, 1'b0, 16'h0C5E);
    do_op("tie_even_up",   16'h0A6A, 16'h92BA, 1'b0, 16'h9120);
    do_op("cancel_1",      16'hC49A, 16'h4429, 1'b0, 16'hB710);
    do_op("cancel_2",      16'h43E2, 16'hC1AC, 1'b0, 16'h3C6C);
    do_op("cancel_3",      16'hBA9D, 16'h4148, 1'b0, 16'h3F42);
    do_op("absorb_1",      16'h522C, 16'h87E6, 1'b0, 16'h522C);
    do_op("absorb_2",      16'h6DA0, 16'hAB89, 1'b0, 16'h6DA0);
    do_op("absorb_3",      16'hBB67, 16'hF5CB, 1'b0, 16'hF5CB);
    do_op("exact_zero",    16'hBA9D, 16'h3A9D, 1'b0, 16'h0000);
    do_op("sub_zero",      16'h3A9D, 16'h3A9D, 1'b1, 16'h0000);
    do_op("neg_zero_sum",  16'h8000, 16'h8000, 1'b0, 16'h8000);
    do_op("mixed_zero",    16'h8000, 16'h0000, 1'b0, 16'h0000);
    do_op("inf_minus_inf", 16'h7C00, 16'hFC00, 1'b0, 16'h7E00);
    do_op("nan_in",        16'h7D01, 16'h3C00, 1'b0, 16'h7E00);
    do_op("inf_plus_fin",  16'hFC00, 16'h7BFF, 1'b0, 16'hFC00);
    do_op("overflow",      16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00);
    do_op("subnormal",     16'h0001, 16'h0001, 1'b0, 16'h0002);
    do_op("sub_to_normal", 16'h03FF, 16'h0001, 1'b0, 16'h0400);
    do_op("sub_flip",      16'h3C00, 16'hBC00, 1'b1, 16'h4000);

    // Asynchronous reset mid-stream: s clears between clock edges.
    a = 16'h3C00;
    b = 16'h3C00;
    sub = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", s, 16'h0000);
    @(posedge clk);
    #1;
    check("reset_held_edge", s, 16'h0000);
    rst_n = 1'b1;
    do_op("after_reset", 16'h3C00, 16'h3C00, 1'b0, 16'h4000);

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rs  = 1'($urandom);
      case (sel)
        1: rb = ra ^ 16'($urandom_range(0, 255)) ^ {~rs, 15'b0};
        2: begin
          ra[14:10] = 5'($urandom_range(0, 2));
          rb[14:10] = 5'($urandom_range(0, 2));
        end
        3: begin
          ra[14:10] = 5'($urandom_range(17, 30));
          rb[14:10] = ra[14:10] - 5'($urandom_range(9, 16));
        end
        default: ;
      endcase
      do_op("random", ra, rb, rs, ref_add(ra, rb, rs));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_adder.md
# fp_adder

IEEE 754 binary16 (half-precision) adder/subtractor with a registered result. It computes s = a + b, or s = a − b when sub is high, with round-to-nearest-even. It handles subnormals, infinities and NaN. It is a standalone arithmetic leaf for datapaths that need half-precision accumulation.

## Interface
- No parameters. Widths are fixed by the binary16 format: 1 sign bit, 5 exponent bits (bias 15), 10 fraction bits.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- a  input  16  operand A, binary16.
- b  input  16  operand B, binary16.
- sub  input  1  0 computes a + b; 1 computes a − b (sign of b is inverted before addition).
- s  output  16  registered binary16 result.

## Operation
- Effective operand: b' = {b[15] ^ sub, b[14:0]}.
- Unpack each operand:
  - exp = 0: subnormal; hidden bit 0, effective exponent 1.
  - exp 1..30: normal; hidden bit 1.
  - exp = 31: infinity or NaN.
- Special cases, evaluated first:
  - Either operand NaN → 16'h7E00 (canonical quiet NaN).
  - +inf + −inf → 16'h7E00.
  - One or both operands infinite (same sign) → that infinity.
- Alignment:
  - Swap so that the larger magnitude is the first operand.
  - Right-shift the smaller significand by the exponent difference.
  - Keep guard and round bits; OR all bits shifted beyond them into sticky. A shift of 14 or more leaves only sticky.
- Add or subtract the significands according to the sign XOR. The result sign is the sign of the larger-magnitude operand.
- Normalize:
  - On carry-out, shift right by 1 and increment the exponent.
  - Otherwise left-shift by the leading-zero count, limited so the exponent does not drop below 1. A result below the normal range becomes subnormal (exp field 0).
- Round to nearest, ties to even, using guard/round/sticky. If rounding carries out of the mantissa, renormalize. A subnormal can round up into the smallest normal.
- Overflow: exponent ≥ 31 after rounding → ±inf (16'h7C00 / 16'hFC00).
- Exact zero from the subtraction of unequal-sign operands → +0 (16'h0000). (−0) + (−0) → 16'h8000.

## Timing
- The datapath from a/b/sub to the register input is combinational within one cycle.
- s is registered on the rising clk edge. Latency is 1 cycle: s reflects the inputs present at the previous rising edge.
- Throughput is one operation per cycle. There is no handshake; new operands are accepted every cycle.
- rst_n low → s = 16'h0000 immediately (asynchronous), and s holds 0 while reset is asserted.
- On the first rising edge after rst_n deasserts, s captures the result for the inputs present at that edge.
- Reset asserted mid-stream discards the in-flight result. There is no other state.

## Structure
- A shared package fp16_pkg holds:
  - field widths (EXP_W = 5, FRAC_W = 10), EXP_BIAS = 15, EXP_MAX = 31;
  - constants QNAN = 16'h7E00, POS_INF = 16'h7C00, NEG_INF = 16'hFC00;
  - a packed struct {sign, exp, frac} for binary16.
- One sub-module, fp_adder_lzc: a 14-bit leading-zero counter used for post-subtraction normalization.
- Unpack, align, add, round and pack stay in fp_adder, ahead of the single output register.

## Test plan
- Rounding tie to even, down: a = 0FCC, b = 8ADB, sub = 0 → s = 0C5E one cycle later.
- Rounding tie to even, up, with sign from the larger-magnitude operand: a = 0A6A, b = 92BA → s = 9120.
- Massive cancellation and renormalization:
  - C49A + 4429 → B710;
  - 43E2 + C1AC → 3C6C;
  - BA9D + 4148 → 3F42.
- Small operand fully absorbed into sticky:
  - 522C + 87E6 → 522C;
  - 6DA0 + AB89 → 6DA0;
  - BB67 + F5CB → F5CB.
- Exact cancellation and the sub input:
  - BA9D + 3A9D → 0000;
  - a = 3A9D, b = 3A9D, sub = 1 → 0000;
  - 3C00 − BC00 → 4000.
- Specials and reset:
  - 7C00 + FC00 → 7E00;
  - 7BFF + 7BFF → 7C00;
  - 0001 + 0001 → 0002;
  - assert rst_n = 0 mid-stream → s = 0000 without waiting for a clock edge.
